conv_encoder: RTL

- Rate-1/2, constraint-length-4 convolutional encoder. It is the transmit-side counterpart of the Viterbi decoder's trellis and traceback path.
- Accepts a framed serial bit stream on a valid/ready handshake and emits one 2-bit code symbol per input bit.
- After the last info bit it appends K-1 = 3 zero tail bits, so every frame terminates in trellis state 000. The decoder's traceback starts from that state.
- Output is fully registered and drives the channel/symbol FIFO feeding the branch-metric unit.

---
 rtl/conv_encoder.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/conv_encoder.sv
// Rate-1/2, K=4 convolutional encoder with zero-tail termination and a registered symbol output.
// Define CONV_PUNCTURE_EN to enable rate-2/3 puncturing (P0=11, P1=10).
module conv_encoder #(
    parameter logic [3:0] G0       = 4'b1111,
    parameter logic [3:0] G1       = 4'b1101,
    parameter int         MAX_BITS = 256,
    parameter int         CNT_W    = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       s_bit,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    output logic [1:0] m_sym,
    output logic [1:0] m_mask,
    output logic       m_valid,
    output logic       m_last,
    input  logic       m_ready,
    output logic       busy,
    output logic       err_overlen
);

    typedef enum logic [1:0] {IDLE, DATA, TAIL} state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BITS);

    state_t             r_state;
    state_t             w_stateNext;
    logic [2:0]         r_sr;
    logic [CNT_W-1:0]   r_bitCnt;
    logic [CNT_W-1:0]   w_cntNext;
    logic [1:0]         r_tailCnt;
    logic [1:0]         r_mSym;
    logic [1:0]         r_mMask;
    logic               r_mValid;
    logic               r_mLast;
    logic               r_err;

    logic               w_slotFree;
    logic               w_accept;
    logic               w_load;
    logic               w_b;
    logic               w_lastSym;
    logic               w_overlen;
    logic [3:0]         w_win;
    logic [1:0]         w_raw;
    logic [1:0]         w_symNext;
    logic [1:0]         w_maskNext;

    assign w_slotFree  = !r_mValid || m_ready;
    assign s_ready     = enable && (r_state != TAIL) && w_slotFree;
    assign w_accept    = s_valid && s_ready;

    assign w_win       = {w_b, r_sr};
    assign w_raw[0]    = ^(w_win & G0);
    assign w_raw[1]    = ^(w_win & G1);

`ifdef CONV_PUNCTURE_EN
    logic r_phase;
    logic w_curPhase;

    // Every frame starts on phase 0, so the first symbol out of IDLE ignores the stored phase.
    assign w_curPhase  = (r_state == IDLE) ? 1'b0 : r_phase;
    assign w_symNext   = w_curPhase ? {1'b0, w_raw[0]} : w_raw;
    assign w_maskNext  = w_curPhase ? 2'b01 : 2'b11;
`else
    assign w_symNext   = w_raw;
    assign w_maskNext  = 2'b11;
`endif

    always_comb begin
        w_stateNext = r_state;
        w_load      = 1'b0;
        w_b         = 1'b0;
        w_lastSym   = 1'b0;
        w_overlen   = 1'b0;
        w_cntNext   = (r_state == IDLE) ? CNT_W'(1) : r_bitCnt + 1'b1;
        if (!enable) begin
            w_stateNext = IDLE;
        end else begin
            case (r_state)
                IDLE, DATA: begin
                    if (w_accept) begin
                        w_load = 1'b1;
                        w_b    = s_bit;
                        if (s_last) begin
                            w_stateNext = TAIL;
                        end else if (w_cntNext == MAX_CNT) begin
                            w_stateNext = TAIL;
                            w_overlen   = 1'b1;
                        end else begin
                            w_stateNext = DATA;
                        end
                    end
                end
                TAIL: begin
                    if (w_slotFree) begin
                        w_load = 1'b1;
                        if (r_tailCnt == 2'd2) begin
                            w_lastSym   = 1'b1;
                            w_stateNext = IDLE;
                        end
                    end
                end
                default: w_stateNext = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sr      <= 3'b000;
            r_bitCnt  <= '0;
            r_tailCnt <= 2'd0;
            r_mSym    <= 2'b00;
            r_mMask   <= 2'b00;
            r_mValid  <= 1'b0;
            r_mLast   <= 1'b0;
            r_err     <= 1'b0;
        end else if (!enable) begin
            r_sr      <= 3'b000;
            r_bitCnt  <= '0;
            r_tailCnt <= 2'd0;
            r_mValid  <= 1'b0;
            r_mLast   <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_err <= w_overlen;
            if (w_load) begin
                r_sr     <= {w_b, r_sr[2:1]};
                r_mSym   <= w_symNext;
                r_mMask  <= w_maskNext;
                r_mValid <= 1'b1;
                r_mLast  <= w_lastSym;
            end else if (m_ready) begin
                r_mValid <= 1'b0;
                r_mLast  <= 1'b0;
            end
            if (w_accept) begin
                r_bitCnt <= w_cntNext;
            end
            if (w_lastSym) begin
                r_bitCnt  <= '0;
                r_tailCnt <= 2'd0;
            end else if (w_load && r_state == TAIL) begin
                r_tailCnt <= r_tailCnt + 2'd1;
            end
        end
    end

`ifdef CONV_PUNCTURE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase <= 1'b0;
        end else if (!enable) begin
            r_phase <= 1'b0;
        end else if (w_load) begin
            r_phase <= ~w_curPhase;
        end
    end
`endif

    assign m_sym       = r_mSym;
    assign m_mask      = r_mMask;
    assign m_valid     = r_mValid;
    assign m_last      = r_mLast;
    assign err_overlen = r_err;
    assign busy        = (r_state != IDLE) || r_mValid;

endmodule
